// File: rtl/mux_scan_serializer.sv
// Sequencer for a 32:1 select-mux: steps S across an inclusive index window,
// samples Y at each step and emits the bits serially over valid/ready.
module mux_scan_serializer #(
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] first_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] S,
    input  logic             Y,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a bit transfers on any rising edge where dout_valid and
    // dout_ready are both high; dout_valid then never drops without a transfer.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] r_sel;
    logic             r_dout;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_cap;

    // A new bit may be captured when the output slot is empty or being consumed.
    assign w_cap = ~r_valid | dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= '0;
            r_sel   <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_last  <= last_i;
                        r_sel   <= first_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_cap) begin
                        r_dout  <= Y;
                        r_valid <= 1'b1;
                        if (r_sel == r_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_sel <= r_sel + ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_valid && dout_ready) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S           = r_sel;
    assign dout        = r_dout;
    assign dout_valid  = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: behavioural mux, scoreboard of expected bits,
// directed window cases plus randomized windows and backpressure.
module tb_mux_scan_serializer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] first_i;
    logic [4:0] last_i;
    logic [4:0] S;
    logic       Y;
    logic       dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    logic [31:0] mux_in;
    logic [0:0]  exp_q[$];
    int          ntot;
    int          nbad;
    int          n_pop;
    int          rdy_mode;
    bit          done_pending;

    mux_scan_serializer #(.SEL_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_i    (first_i),
        .last_i     (last_i),
        .S          (S),
        .Y          (Y),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .o_dbg_state(dbg_state)
    );

    assign Y = mux_in[S];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        int cnt;
        cnt = 0;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       dout_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b1;
            endcase
            cnt++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [0:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pending = 1'b0;
            end else begin
                if (done || done_pending) check("done_pulse", done, done_pending);
                done_pending = 1'b0;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout_bit", dout, e);
                        n_pop++;
                        if (exp_q.size() == 0) done_pending = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic push_window(input int f, input int l);
        int n;
        n = ((l - f) & 31) + 1;
        for (int k = 0; k < n; k++) exp_q.push_back(mux_in[(f + k) % 32]);
    endtask

    // Issues a start and follows the scan until done; optional latency/S/busy
    // checks assume dout_ready held high. Returns inside the done cycle.
    task automatic scan(input int f, input int l, input bit chk_lat, input bit mid);
        int n;
        int c;
        bit got;
        n = ((l - f) & 31) + 1;
        push_window(f, l);
        first_i = 5'(f);
        last_i  = 5'(l);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 1;
        got = 0;
        while (c < 400 && !got) begin
            @(negedge clk);
            if (chk_lat && c <= n) check("s_seq", S, (f + c - 1) % 32);
            if (chk_lat && c <= n + 1) check("busy_hi", busy, 1);
            if (done) begin
                got = 1;
            end else begin
                @(posedge clk);
                #1;
                start = mid && (c == 1);
                if (start) begin
                    first_i = 5'(f + 7);
                    last_i  = 5'(f + 9);
                end
                c++;
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        if (chk_lat) check("done_latency", c, n + 2);
        check("s_home", S, 0);
        check("busy_lo", busy, 0);
        check("valid_lo", dout_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f;
        int l;
        bit ok;
        ntot = 0;
        nbad = 0;
        n_pop = 0;
        rdy_mode = 0;
        done_pending = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        first_i = '0;
        last_i = '0;
        mux_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_S", S, 0);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);

        mux_in = 32'hA5C3_0F96;
        scan(0, 31, 1, 0);
        mux_in = 32'h8000_0001;
        scan(30, 1, 1, 0);
        mux_in = 32'h0002_0000;
        scan(17, 17, 1, 0);

        // back-pressure pattern 1,0,0,1
        mux_in = $urandom;
        rdy_mode = 1;
        scan(0, 31, 0, 0);
        rdy_mode = 0;

        // start during RUN with a different window must be ignored
        mux_in = $urandom;
        scan(3, 20, 1, 1);

        // reset after 10 consumed bits
        @(posedge clk);
        #1;
        mux_in = $urandom;
        n_pop = 0;
        push_window(0, 31);
        first_i = 5'd0;
        last_i = 5'd31;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (n_pop >= 10) ok = 1;
        end
        check("ten_bits_seen", ok, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_S", S, 0);
        check("abort_valid", dout_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_state", dbg_state, 0);
        mux_in = $urandom;
        scan(9, 14, 1, 0);

        // randomized windows, ready either high or random
        for (int i = 0; i < 24; i++) begin
            mux_in = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            rdy_mode = (i % 2 == 0) ? 0 : 2;
            scan(f, l, rdy_mode == 0, i % 5 == 1);
        end
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
